sif_wbridge: RTL and testbench



---
 rtl/sif_wbridge_if.sv | 26 ++
 rtl/sif_wbridge.sv | 129 ++++++++++++
 tb/tb_sif_wbridge.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sif_wbridge_if.sv
// Signal bundle between the SIF host (X) port, the write bridge and the W-side write port.
// The slave modport is the bridge's view; the master modport is the host/downstream view.
interface sif_wbridge_if;
   logic [15:0] xa_addr;
   logic [15:0] xa_data_wr;
   logic        xa_wr_s;
   logic        xa_rd_s;
   logic [15:0] xa_data_rd;
   logic        xa_rd_valid;
   logic        xa_busy;
   logic        err_drop;
   logic [15:0] wa_addr;
   logic [15:0] wa_data_wr;
   logic        wa_wr_s;
   logic        wa_ready;

   modport slave (
      input  xa_addr, xa_data_wr, xa_wr_s, xa_rd_s, wa_ready,
      output xa_data_rd, xa_rd_valid, xa_busy, err_drop, wa_addr, wa_data_wr, wa_wr_s
   );

   modport master (
      output xa_addr, xa_data_wr, xa_wr_s, xa_rd_s, wa_ready,
      input  xa_data_rd, xa_rd_valid, xa_busy, err_drop, wa_addr, wa_data_wr, wa_wr_s
   );
endinterface

// File: rtl/sif_wbridge.sv
// sif_wbridge: buffers host writes in a small FIFO and drains them to the W side under
// valid/ready. Drained writes land in a shadow register file that host reads return.
// Writes still queued in the FIFO are deliberately invisible to reads.
module sif_wbridge #(
   parameter int DEPTH     = 4,
   parameter int SHADOW_AW = 4
) (
   input  logic         clk,
   input  logic         rst,
   sif_wbridge_if.slave bus
);

   localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            CW       = $clog2(DEPTH + 1);
   localparam int            NWORDS   = 1 << SHADOW_AW;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } entry_t;

   entry_t               fifo_q   [DEPTH];
   logic [15:0]          shadow_q [NWORDS];

   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q,  count_d;
   logic [15:0]          rd_data_q, rd_data_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 err_drop_q, err_drop_d;

   logic                 full;
   logic                 not_empty;
   logic                 push;
   logic                 pop;
   entry_t               head;
   logic [SHADOW_AW-1:0] rd_idx;
   logic [SHADOW_AW-1:0] wr_idx;

   // Head entry, shadow indices and FIFO status are plain decodes of the registers.
   assign head      = fifo_q[rd_ptr_q];
   assign full      = (count_q == FULL_CNT);
   assign not_empty = (count_q != '0);
   assign rd_idx    = bus.xa_addr[SHADOW_AW-1:0];
   assign wr_idx    = head.addr[SHADOW_AW-1:0];

   // Acceptance looks only at the pre-edge count, so a same-cycle pop never frees a slot.
   assign push = bus.xa_wr_s && !full;
   assign pop  = not_empty && bus.wa_ready;

   // Next-state for pointers, occupancy and the registered host-side outputs.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = bus.xa_rd_s;
      err_drop_d = bus.xa_wr_s && full;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Shadow is read before this edge's drain update, so a colliding read sees the old word.
      if (bus.xa_rd_s) begin
         rd_data_d = shadow_q[rd_idx];
      end
   end

   // Control registers; reset discards queued entries and blocks any transfer at that edge.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         err_drop_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         err_drop_q <= err_drop_d;
      end
   end

   // FIFO storage, written at the tail on every accepted push.
   always_ff @(posedge clk) begin
      // NOTE: the FIFO array has no reset: count and pointers qualify every use of it, so
      // clearing it would change nothing visible.
      if (!rst && push) begin
         fifo_q[wr_ptr_q] <= '{addr: bus.xa_addr, data: bus.xa_data_wr};
      end
   end

   // Shadow file: cleared by reset, then updated with each write drained to the W side.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NWORDS; i++) begin
            shadow_q[i] <= '0;
         end
      end else if (pop) begin
         shadow_q[wr_idx] <= head.data;
      end
   end

   assign bus.xa_data_rd  = rd_data_q;
   assign bus.xa_rd_valid = rd_valid_q;
   assign bus.err_drop    = err_drop_q;
   assign bus.xa_busy     = full;
   assign bus.wa_wr_s     = not_empty;
   assign bus.wa_addr     = head.addr;
   assign bus.wa_data_wr  = head.data;

endmodule

// File: tb/tb_sif_wbridge.sv
// tb_sif_wbridge: drives directed and random host/downstream traffic into sif_wbridge.
// A queue-based reference model predicts W-side transfers, read data and drop pulses;
// a negedge monitor pops those expectations and compares them against the DUT.
module tb_sif_wbridge;

   localparam int DEPTH = 4;
   localparam int SAW   = 4;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst;

   sif_wbridge_if bus ();

   sif_wbridge #(
      .DEPTH     (DEPTH),
      .SHADOW_AW (SAW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model state.
   ent_t        mq[$];
   logic [15:0] sh[1 << SAW];
   logic [15:0] last_rd;
   int          model_pops;

   // Scoreboard queues filled by the model, drained by the monitor.
   ent_t        exp_w[$];
   logic [15:0] exp_rd[$];
   int          exp_drop;
   int          n_xfer;

   int          total;
   int          bad;
   bit          started;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Behavioural model of one clock edge using the inputs presented before that edge.
   task automatic model_step();
      int   n;
      ent_t e;
      if (rst) begin
         mq.delete();
         exp_w.delete();
         exp_drop = 0;
         foreach (sh[i]) sh[i] = '0;
         last_rd = '0;
         return;
      end
      n = mq.size();
      if (bus.xa_rd_s) begin
         last_rd = sh[bus.xa_addr[SAW-1:0]];
         exp_rd.push_back(last_rd);
      end
      if (n != 0 && bus.wa_ready) begin
         e = mq.pop_front();
         sh[e.addr[SAW-1:0]] = e.data;
         model_pops++;
      end
      if (bus.xa_wr_s) begin
         if (n < DEPTH) begin
            e.addr = bus.xa_addr;
            e.data = bus.xa_data_wr;
            mq.push_back(e);
            exp_w.push_back(e);
         end else begin
            exp_drop++;
         end
      end
   endtask

   // Present inputs, clock one edge, update the model, then step 1 time unit off the edge.
   task automatic step(input logic r, input logic w, input logic rd,
                       input logic [15:0] a, input logic [15:0] d, input logic rdy);
      rst            = r;
      bus.xa_wr_s    = w;
      bus.xa_rd_s    = rd;
      bus.xa_addr    = a;
      bus.xa_data_wr = d;
      bus.wa_ready   = rdy;
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Monitor: compare DUT outputs with the scoreboard on every falling edge.
   always @(negedge clk) begin
      if (started) begin
         check("wa_wr_s", 32'(bus.wa_wr_s), 32'(mq.size() != 0));
         check("xa_busy", 32'(bus.xa_busy), 32'(mq.size() == DEPTH));
         if (bus.wa_wr_s === 1'b1 && exp_w.size() > 0) begin
            check("wa_addr", 32'(bus.wa_addr), 32'(exp_w[0].addr));
            check("wa_data_wr", 32'(bus.wa_data_wr), 32'(exp_w[0].data));
            if (bus.wa_ready === 1'b1 && rst === 1'b0) begin
               void'(exp_w.pop_front());
               n_xfer++;
            end
         end
         check("xa_rd_valid", 32'(bus.xa_rd_valid), 32'(exp_rd.size() != 0));
         if (exp_rd.size() > 0) void'(exp_rd.pop_front());
         check("xa_data_rd", 32'(bus.xa_data_rd), 32'(last_rd));
         check("err_drop", 32'(bus.err_drop), 32'(exp_drop > 0));
         if (exp_drop > 0) exp_drop--;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] a;
      total      = 0;
      bad        = 0;
      exp_drop   = 0;
      n_xfer     = 0;
      model_pops = 0;
      last_rd    = '0;
      foreach (sh[i]) sh[i] = '0;
      started    = 1'b1;

      // Reset held two cycles with a write strobe present: nothing may be pushed.
      step(1'b1, 1'b1, 1'b0, 16'h0001, 16'h1234, 1'b0);
      step(1'b1, 1'b1, 1'b0, 16'h0001, 16'h1234, 1'b0);
      check("rst_wa_wr_s", 32'(bus.wa_wr_s), 32'd0);
      check("rst_busy", 32'(bus.xa_busy), 32'd0);
      step(1'b0, 1'b0, 1'b1, 16'h0003, 16'h0000, 1'b1);
      check("rst_read3_valid", 32'(bus.xa_rd_valid), 32'd1);
      check("rst_read3_data", 32'(bus.xa_data_rd), 32'h0000);

      // Single write drained at once, then read back.
      step(1'b0, 1'b1, 1'b0, 16'h0005, 16'hBEEF, 1'b1);
      check("single_wa_addr", 32'(bus.wa_addr), 32'h0005);
      check("single_wa_data", 32'(bus.wa_data_wr), 32'hBEEF);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      step(1'b0, 1'b0, 1'b1, 16'h0005, 16'h0000, 1'b1);
      check("single_read5", 32'(bus.xa_data_rd), 32'hBEEF);

      // Backpressure and overflow: six writes into a stalled FIFO of four.
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 1'b0, 16'h00A0 + 16'(i), 16'hA000 + 16'(i), 1'b0);
         if (i == 3) check("ovf_busy_after_4th", 32'(bus.xa_busy), 32'd1);
         if (i >= 4) check("ovf_err_drop", 32'(bus.err_drop), 32'd1);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

      // Streaming writes with wa_ready toggling, crossing the pointer wrap.
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i), 16'($urandom), (i % 2) == 0);
      end
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

      // Read collision with a pop to the same shadow index (0x0012 aliases to index 2).
      step(1'b0, 1'b1, 1'b0, 16'h0002, 16'h1111, 1'b1);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      step(1'b0, 1'b1, 1'b0, 16'h0012, 16'h2222, 1'b1);
      step(1'b0, 1'b0, 1'b1, 16'h0002, 16'h0000, 1'b1);
      check("collide_old", 32'(bus.xa_data_rd), 32'h1111);
      step(1'b0, 1'b0, 1'b1, 16'h0002, 16'h0000, 1'b1);
      check("collide_new", 32'(bus.xa_data_rd), 32'h2222);

      // Reset mid-drain: queued entries must vanish.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0030 + 16'(i), 16'hC000 + 16'(i), 1'b0);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      check("midrst_wa_wr_s", 32'(bus.wa_wr_s), 32'd0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

      // Random traffic, including occasional resets and aliased addresses.
      for (int i = 0; i < 400; i++) begin
         a = 16'($urandom);
         if ($urandom_range(1) == 1) a = a & 16'h000F;
         step($urandom_range(99) == 0, $urandom_range(99) < 60, $urandom_range(99) < 40,
              a, 16'($urandom), $urandom_range(99) < 55);
      end

      // Drain everything and confirm the scoreboard is empty.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      check("w_leftover", 32'(exp_w.size()), 32'd0);
      check("xfer_count", 32'(n_xfer), 32'(model_pops));

      started = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
